// File: rtl/intersection_scheduler_pkg.sv
// Shared definitions for the intersection scheduler.
// Holds the 3-bit light codes and the 2-bit phase codes used by the scheduler.
// Any other stoplight controller can reuse the same encodings.
// It also provides a small helper that sizes the phase counter.
package intersection_scheduler_pkg;

    // Light codes: bit0 red, bit1 yellow, bit2 green
    localparam logic [2:0] RED = 3'b001;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] GRN = 3'b100;

    // Phase codes; 2'b11 is unused and is treated as a fault to recover from
    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    // Largest of three phase lengths; the counter must be able to hold it
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/intersection_scheduler_rr_pick.sv
// Round-robin picker (combinational).
// It returns the first requester after the current holder, in wrap order.
// It works in three steps. First it rotates the request vector so that the slot after cur lands at bit 0.
// Then it priority-encodes the lowest set bit.
// Finally it rotates the result back to the original positions.
// Ports:
//   req  in  N  candidate requests
//   cur  in  N  one-hot current holder (all-zero means search from 0)
//   pick out N  one-hot winner, all-zero when req is empty
module intersection_scheduler_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] cur,
    output logic [N-1:0] pick
);

    logic [N-1:0] rot;
    logic [N-1:0] pe;
    logic [N:0]   found;
    int           start;

    // Rotation amount: the slot after the current holder becomes bit 0
    always_comb begin
        start = 0;
        for (int i = 0; i < N; i++) begin
            if (cur[i]) start = (i + 1) % N;
        end
    end

    always_comb begin
        rot = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (i == (j + start) % N) rot[j] = req[i];
            end
        end
    end

    // Lowest-set-bit priority encoder as a ripple of "already found" flags
    assign found[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pe
            assign pe[gi]        = rot[gi] & ~found[gi];
            assign found[gi + 1] = found[gi] | rot[gi];
        end
    endgenerate

    always_comb begin
        pick = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                if (i == (j + start) % N) pick[i] = pe[j];
            end
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// Round-robin right-of-way scheduler for a multi-approach intersection.
// It sequences GREEN -> YELLOW -> ALL_RED -> next GREEN.
// Every phase is timed in units of the slow tick strobe.
// Ports:
//   clk     in  1          system clock
//   rst     in  1          asynchronous active-high reset (home green)
//   tick    in  1          one-clk phase timer enable
//   req     in  NUM_APP    level request per approach
//   lights  out 3*NUM_APP  lights[3*i+:3] for approach i (bit0 R, bit1 Y, bit2 G)
//   grant   out NUM_APP    one-hot current / last green approach
//   phase   out 2          00 GREEN, 01 YELLOW, 10 ALL_RED
//   pending out NUM_APP    latched unserved requests
module intersection_scheduler
    import intersection_scheduler_pkg::*;
#(
    parameter int NUM_APP      = 4,
    parameter int MIN_GREEN    = 3,
    parameter int MAX_GREEN    = 6,
    parameter int YELLOW_TICKS = 1,
    parameter int ALLRED_TICKS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [NUM_APP-1:0]     req,
    output logic [3*NUM_APP-1:0]   lights,
    output logic [NUM_APP-1:0]     grant,
    output logic [1:0]             phase,
    output logic [NUM_APP-1:0]     pending
);

    localparam int CNT_TOP = max3(MAX_GREEN, YELLOW_TICKS, ALLRED_TICKS);
    localparam int CW      = $clog2(CNT_TOP + 1);

    phase_t               phase_reg, phase_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [NUM_APP-1:0]   grant_reg, grant_next;
    logic [NUM_APP-1:0]   pending_reg, pending_next;

    logic [CW-1:0]        cnt_inc;
    logic [CW-1:0]        green_c;
    logic                 other;
    logic                 own_req;
    logic                 in_green;
    logic [NUM_APP-1:0]   pick;

    intersection_scheduler_rr_pick #(
        .N (NUM_APP)
    ) u_rr_pick (
        .req  (pending_reg),
        .cur  (grant_reg),
        .pick (pick)
    );

    assign in_green = (phase_reg == PH_GREEN);
    assign cnt_inc  = cnt_reg + CW'(1);
    // The green count saturates so that a long solo green cannot wrap the counter
    assign green_c  = (cnt_reg >= CW'(MAX_GREEN)) ? CW'(MAX_GREEN) : cnt_inc;
    assign other    = |(pending_reg & ~grant_reg);
    assign own_req  = |(req & grant_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg   <= PH_GREEN;
            cnt_reg     <= '0;
            grant_reg   <= NUM_APP'(1);
            pending_reg <= '0;
        end else begin
            phase_reg   <= phase_next;
            cnt_reg     <= cnt_next;
            grant_reg   <= grant_next;
            pending_reg <= pending_next;
        end
    end

    always_comb begin
        phase_next   = phase_reg;
        cnt_next     = cnt_reg;
        grant_next   = grant_reg;
        // The approach that is showing green absorbs its own request instead of latching it
        pending_next = pending_reg | (req & ~(grant_reg & {NUM_APP{in_green}}));

        case (phase_reg)
            PH_GREEN: begin
                if (tick) begin
                    if (green_c >= CW'(MIN_GREEN) && other &&
                        (!own_req || green_c >= CW'(MAX_GREEN))) begin
                        phase_next = PH_YELLOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = green_c;
                    end
                end
            end
            PH_YELLOW: begin
                if (tick) begin
                    if (cnt_inc == CW'(YELLOW_TICKS)) begin
                        phase_next = PH_ALLRED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt_inc;
                    end
                end
            end
            PH_ALLRED: begin
                if (tick) begin
                    if (cnt_inc == CW'(ALLRED_TICKS)) begin
                        phase_next   = PH_GREEN;
                        cnt_next     = '0;
                        grant_next   = pick;
                        // A request from the new green approach in this very cycle is dropped
                        pending_next = pending_next & ~pick;
                    end else begin
                        cnt_next     = cnt_inc;
                    end
                end
            end
            default: begin
                // Corrupted phase encoding: clear the junction, then resume normally
                phase_next = PH_ALLRED;
                cnt_next   = '0;
            end
        endcase
    end

    assign grant   = grant_reg;
    assign phase   = phase_reg;
    assign pending = pending_reg;

    generate
        for (genvar gi = 0; gi < NUM_APP; gi++) begin : g_lights
            assign lights[3*gi +: 3] =
                (grant_reg[gi] && phase_reg == PH_GREEN)  ? GRN :
                (grant_reg[gi] && phase_reg == PH_YELLOW) ? YLW : RED;
        end
    endgenerate

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [3:0]  req;
    logic [11:0] lights;
    logic [3:0]  grant;
    logic [1:0]  phase;
    logic [3:0]  pending;

    intersection_scheduler #(
        .NUM_APP      (4),
        .MIN_GREEN    (3),
        .MAX_GREEN    (6),
        .YELLOW_TICKS (1),
        .ALLRED_TICKS (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .req     (req),
        .lights  (lights),
        .grant   (grant),
        .phase   (phase),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] L_HOME = 12'b001_001_001_100;
    localparam logic [11:0] L_Y0   = 12'b001_001_001_010;
    localparam logic [11:0] L_AR   = 12'b001_001_001_001;
    localparam logic [11:0] L_G1   = 12'b001_001_100_001;
    localparam logic [11:0] L_G2   = 12'b001_100_001_001;
    localparam logic [11:0] L_Y2   = 12'b001_010_001_001;
    localparam logic [11:0] L_G3   = 12'b100_001_001_001;

    typedef struct {
        string       name;
        logic [3:0]  g;
        logic [1:0]  ph;
        logic [11:0] lt;
        logic [3:0]  pd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    task automatic expect_st(input string nm, input logic [3:0] g, input logic [1:0] ph,
                             input logic [11:0] lt, input logic [3:0] pd);
        exp_t e;
        e.name = nm; e.g = g; e.ph = ph; e.lt = lt; e.pd = pd;
        sb.push_back(e);
    endtask

    // Monitor: pops each expected record and compares against the live outputs
    initial begin : monitor
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            e = sb.pop_front();
            n_cmp += 4;
            if (grant !== e.g) begin
                n_fail++;
                $display("FAIL %s grant: got %b want %b", e.name, grant, e.g);
            end
            if (phase !== e.ph) begin
                n_fail++;
                $display("FAIL %s phase: got %b want %b", e.name, phase, e.ph);
            end
            if (lights !== e.lt) begin
                n_fail++;
                $display("FAIL %s lights: got %b want %b", e.name, lights, e.lt);
            end
            if (pending !== e.pd) begin
                n_fail++;
                $display("FAIL %s pending: got %b want %b", e.name, pending, e.pd);
            end
            $display("chk %-12s grant=%b phase=%b lights=%b pending=%b", e.name, grant, phase, lights, pending);
        end
    end

    // One clock: drive inputs just after a falling edge, return at the next falling edge
    task automatic cyc(input logic tk, input logic [3:0] r);
        tick = tk;
        req  = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b0;
        req  = '0;
        #1;
        expect_st("reset", 4'b0001, 2'b00, L_HOME, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        rst  = 1'b1;
        tick = 1'b0;
        req  = '0;

        // 1: idle home green for 20 ticks
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'b0000);
            if (i % 5 == 4) expect_st("t1_idle", 4'b0001, 2'b00, L_HOME, 4'b0000);
        end

        // 2: one-clk pulse on approach 2
        do_reset();
        cyc(1'b0, 4'b0100); expect_st("t2_latch", 4'b0001, 2'b00, L_HOME, 4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t2_tick1", 4'b0001, 2'b00, L_HOME, 4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t2_tick2", 4'b0001, 2'b00, L_HOME, 4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t2_tick3", 4'b0001, 2'b01, L_Y0,   4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t2_tick4", 4'b0001, 2'b10, L_AR,   4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t2_tick5", 4'b0100, 2'b00, L_G2,   4'b0000);

        // 3: home request held, approach 1 pulsed -> green extends to MAX
        do_reset();
        cyc(1'b0, 4'b0011); expect_st("t3_latch", 4'b0001, 2'b00, L_HOME, 4'b0010);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 4'b0001);
        expect_st("t3_tick5", 4'b0001, 2'b00, L_HOME, 4'b0010);
        cyc(1'b1, 4'b0001); expect_st("t3_tick6", 4'b0001, 2'b01, L_Y0, 4'b0010);
        cyc(1'b1, 4'b0001); expect_st("t3_tick7", 4'b0001, 2'b10, L_AR, 4'b0011);
        cyc(1'b1, 4'b0001); expect_st("t3_tick8", 4'b0010, 2'b00, L_G1, 4'b0001);

        // 4: from grant 0100, approaches 1 and 3 together -> 3 then 1 (wrap)
        do_reset();
        cyc(1'b0, 4'b0100);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000);
        expect_st("t4_g2", 4'b0100, 2'b00, L_G2, 4'b0000);
        cyc(1'b0, 4'b1010); expect_st("t4_latch", 4'b0100, 2'b00, L_G2, 4'b1010);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000);
        expect_st("t4_yel", 4'b0100, 2'b01, L_Y2, 4'b1010);
        for (int i = 0; i < 2; i++) cyc(1'b1, 4'b0000);
        expect_st("t4_g3", 4'b1000, 2'b00, L_G3, 4'b0010);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000);
        expect_st("t4_g1", 4'b0010, 2'b00, L_G1, 4'b0000);

        // 5: asynchronous reset in the middle of yellow
        do_reset();
        cyc(1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b1000); expect_st("t5_yel", 4'b0001, 2'b01, L_Y0, 4'b1100);
        #2 rst = 1'b1;
        #1 expect_st("t5_async", 4'b0001, 2'b00, L_HOME, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 4'b0000); expect_st("t5_after", 4'b0001, 2'b00, L_HOME, 4'b0000);

        // 6: no tick freezes everything; tick every clk runs the full sequence in 5 clks
        do_reset();
        cyc(1'b0, 4'b0100);
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 4'b0000);
            if (i % 10 == 9) expect_st("t6_frozen", 4'b0001, 2'b00, L_HOME, 4'b0100);
        end
        cyc(1'b1, 4'b0000); expect_st("t6_clk1", 4'b0001, 2'b00, L_HOME, 4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t6_clk2", 4'b0001, 2'b00, L_HOME, 4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t6_clk3", 4'b0001, 2'b01, L_Y0,   4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t6_clk4", 4'b0001, 2'b10, L_AR,   4'b0100);
        cyc(1'b1, 4'b0000); expect_st("t6_clk5", 4'b0100, 2'b00, L_G2,   4'b0000);

        stim_done = 1'b1;
        wait (sb.size() == 0);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: timeout, stim_done=%0b queued=%0d", stim_done, sb.size());
        $fatal(1, "timeout");
    end

endmodule
